apb_stdout_linebuf: RTL and testbench

- Synthesizable, parametrised successor to the simulation-only APB stdout sink.
- Accepts per-core character writes over APB into per-channel line buffers (channel = cluster × core).
- On newline, full buffer or external flush, commits the line and streams it out as a byte stream tagged with the channel ID.
- Sits on the peripheral APB; the stream feeds a host-visible FIFO/UART/debug core.

---
 rtl/apb_stdout_linebuf.sv | 231 +++++++++++++++++++++++
 tb/tb_apb_stdout_linebuf.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_stdout_linebuf.sv
// APB character sink with per-channel line buffers and a round-robin byte stream out.
// Each channel (cluster x core) collects characters until a newline, a full buffer or
// an external flush, then the drain engine streams the committed line out tagged with
// its channel number.
`timescale 1ns/1ps
module apb_stdout_linebuf #(
  parameter int unsigned N_CLUSTERS = 4,
  parameter int unsigned N_CORES    = 8,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LINE_DEPTH = 64,
  localparam int unsigned N_CH      = N_CLUSTERS * N_CORES,
  localparam int unsigned CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  apb_psel,
  input  logic                  apb_penable,
  input  logic                  apb_pwrite,
  input  logic [ADDR_WIDTH-1:0] apb_paddr,
  input  logic [DATA_WIDTH-1:0] apb_pwdata,
  output logic [DATA_WIDTH-1:0] apb_prdata,
  output logic                  apb_pready,
  output logic                  apb_pslverr,
  input  logic                  flush_i,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [7:0]            m_data_o,
  output logic [CH_W-1:0]       m_chan_o,
  output logic                  m_last_o,
  output logic [15:0]           drop_cnt_o
);

  localparam int unsigned LIDX_W = $clog2(LINE_DEPTH);
  localparam int unsigned LW     = LIDX_W + 1;
  localparam int unsigned AW     = CH_W + LIDX_W;

  typedef enum logic {CH_FILL, CH_COMMITTED} ch_state_e;
  typedef enum logic {DR_IDLE, DR_SEND} dr_state_e;

  ch_state_e         ch_state_q [N_CH];
  ch_state_e         ch_state_d [N_CH];
  logic [LW-1:0]     level_q    [N_CH];
  logic [LW-1:0]     level_d    [N_CH];
  logic [15:0]       drop_q, drop_d;

  dr_state_e         dr_state_q, dr_state_d;
  logic              m_valid_q, m_valid_d;
  logic [7:0]        m_data_q, m_data_d;
  logic [CH_W-1:0]   m_chan_q, m_chan_d;
  logic              m_last_q, m_last_d;
  logic [LW-1:0]     rd_idx_q, rd_idx_d;
  logic [CH_W-1:0]   rr_q, rr_d;
  logic              free_en;

  logic [7:0]        line_mem [N_CH*LINE_DEPTH];
  logic              mem_we;
  logic [AW-1:0]     mem_waddr;
  logic [AW-1:0]     rd_addr;

  logic [3:0]        addr_cl, addr_core;
  logic              in_range;
  logic [CH_W-1:0]   dec_chan;
  logic              wr_fire;
  logic [7:0]        wr_char;
  logic [LW-1:0]     cur_level;
  logic [31:0]       status;
  logic              grant_found;
  logic [CH_W-1:0]   grant_chan;
  int                cand;
  logic              unused_bits;

  assign unused_bits = ^{apb_paddr[ADDR_WIDTH-1:11], apb_paddr[2:0], apb_pwdata[DATA_WIDTH-1:8]};

  assign addr_cl   = apb_paddr[10:7];
  assign addr_core = apb_paddr[6:3];
  assign in_range  = (32'(addr_cl) < N_CLUSTERS) && (32'(addr_core) < N_CORES);
  assign dec_chan  = in_range ? CH_W'(32'(addr_cl) * N_CORES + 32'(addr_core)) : '0;
  assign wr_char   = apb_pwdata[7:0];

  // A committed channel cannot accept characters until its line has been drained.
  assign apb_pready  = ~(apb_psel & apb_pwrite & in_range & (ch_state_q[dec_chan] == CH_COMMITTED));
  assign apb_pslverr = apb_psel & apb_penable & ~in_range;
  assign wr_fire     = apb_psel & apb_penable & apb_pwrite & apb_pready & in_range;

  // Status word for the addressed channel; out-of-range addresses read as zero.
  always_comb begin
    status = 32'h0;
    if (in_range) begin
      status[0]     = (ch_state_q[dec_chan] == CH_COMMITTED);
      status[15:8]  = 8'(level_q[dec_chan]);
      status[31:16] = drop_q;
    end
  end
  assign apb_prdata = DATA_WIDTH'(status);

  // Channel bookkeeping: store/commit on writes, then flush, then release after drain.
  always_comb begin
    ch_state_d = ch_state_q;
    level_d    = level_q;
    drop_d     = drop_q;
    mem_we     = 1'b0;
    cur_level  = level_q[dec_chan];
    mem_waddr  = {dec_chan, cur_level[LIDX_W-1:0]};
    if (wr_fire) begin
      if (wr_char == 8'h0A) begin
        if (cur_level != '0) ch_state_d[dec_chan] = CH_COMMITTED;
      end else begin
        mem_we            = 1'b1;
        level_d[dec_chan] = cur_level + LW'(1);
        if (cur_level + LW'(1) == LW'(LINE_DEPTH)) begin
          ch_state_d[dec_chan] = CH_COMMITTED;
          if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
        end
      end
    end
    if (flush_i) begin
      for (int i = 0; i < N_CH; i++) begin
        if (ch_state_q[i] == CH_FILL && level_d[i] != '0) ch_state_d[i] = CH_COMMITTED;
      end
    end
    if (free_en) begin
      ch_state_d[m_chan_q] = CH_FILL;
      level_d[m_chan_q]    = '0;
    end
  end

  // Round-robin search for the first committed channel at or after the pointer.
  always_comb begin
    grant_found = 1'b0;
    grant_chan  = '0;
    cand        = 0;
    for (int i = 0; i < N_CH; i++) begin
      cand = int'(rr_q) + i;
      if (cand >= int'(N_CH)) cand = cand - int'(N_CH);
      if (!grant_found && ch_state_q[CH_W'(cand)] == CH_COMMITTED) begin
        grant_found = 1'b1;
        grant_chan  = CH_W'(cand);
      end
    end
  end

  // Drain engine: grant loads byte 0 directly so only one idle cycle separates lines.
  always_comb begin
    dr_state_d = dr_state_q;
    m_valid_d  = m_valid_q;
    m_data_d   = m_data_q;
    m_chan_d   = m_chan_q;
    m_last_d   = m_last_q;
    rd_idx_d   = rd_idx_q;
    rr_d       = rr_q;
    free_en    = 1'b0;
    rd_addr    = {m_chan_q, rd_idx_q[LIDX_W-1:0]};
    case (dr_state_q)
      DR_IDLE: begin
        if (grant_found) begin
          rd_addr    = {grant_chan, LIDX_W'(0)};
          m_data_d   = line_mem[rd_addr];
          m_chan_d   = grant_chan;
          m_last_d   = (level_q[grant_chan] == LW'(1));
          m_valid_d  = 1'b1;
          rd_idx_d   = LW'(1);
          rr_d       = (grant_chan == CH_W'(N_CH - 1)) ? '0 : grant_chan + CH_W'(1);
          dr_state_d = DR_SEND;
        end
      end
      DR_SEND: begin
        if (m_ready_i) begin
          if (m_last_q) begin
            m_valid_d  = 1'b0;
            m_last_d   = 1'b0;
            free_en    = 1'b1;
            dr_state_d = DR_IDLE;
          end else begin
            m_data_d = line_mem[rd_addr];
            m_last_d = (rd_idx_q == level_q[m_chan_q] - LW'(1));
            rd_idx_d = rd_idx_q + LW'(1);
          end
        end
      end
    endcase
  end

  // Line storage: APB writes only, no reset needed so it can map onto RAM.
  always_ff @(posedge clk_i) begin
    if (mem_we) line_mem[mem_waddr] <= wr_char;
  end

  // Per-channel state and the drop counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < N_CH; i++) begin
        ch_state_q[i] <= CH_FILL;
        level_q[i]    <= '0;
      end
      drop_q <= '0;
    end else begin
      ch_state_q <= ch_state_d;
      level_q    <= level_d;
      drop_q     <= drop_d;
    end
  end

  // Drain engine registers and the registered stream outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dr_state_q <= DR_IDLE;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      m_chan_q   <= '0;
      m_last_q   <= 1'b0;
      rd_idx_q   <= '0;
      rr_q       <= '0;
    end else begin
      dr_state_q <= dr_state_d;
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
      m_chan_q   <= m_chan_d;
      m_last_q   <= m_last_d;
      rd_idx_q   <= rd_idx_d;
      rr_q       <= rr_d;
    end
  end

  assign m_valid_o  = m_valid_q;
  assign m_data_o   = m_data_q;
  assign m_chan_o   = m_chan_q;
  assign m_last_o   = m_last_q;
  assign drop_cnt_o = drop_q;

endmodule

// File: tb/tb_apb_stdout_linebuf.sv
// Directed bench for apb_stdout_linebuf with 4 clusters, 8 cores and 4-byte lines.
`timescale 1ns/1ps
module tb_apb_stdout_linebuf;

  localparam int NCL = 4;
  localparam int NCO = 8;
  localparam int LD  = 4;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        apb_psel = 1'b0;
  logic        apb_penable = 1'b0;
  logic        apb_pwrite = 1'b0;
  logic [31:0] apb_paddr = '0;
  logic [31:0] apb_pwdata = '0;
  logic [31:0] apb_prdata;
  logic        apb_pready;
  logic        apb_pslverr;
  logic        flush_i = 1'b0;
  logic        m_valid_o;
  logic        m_ready_i = 1'b1;
  logic [7:0]  m_data_o;
  logic [4:0]  m_chan_o;
  logic        m_last_o;
  logic [15:0] drop_cnt_o;

  int          n_checks = 0;
  int          n_bad = 0;
  int          stall_checks = 0;
  logic [13:0] got_q [$];
  logic [13:0] exp_q [$];
  logic        prev_stall = 1'b0;
  logic [13:0] prev_beat = '0;
  int          w3;
  logic        e3;

  always #5 clk_i = ~clk_i;

  apb_stdout_linebuf #(
    .N_CLUSTERS(NCL), .N_CORES(NCO), .ADDR_WIDTH(32), .DATA_WIDTH(32), .LINE_DEPTH(LD)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .apb_psel(apb_psel), .apb_penable(apb_penable), .apb_pwrite(apb_pwrite),
    .apb_paddr(apb_paddr), .apb_pwdata(apb_pwdata), .apb_prdata(apb_prdata),
    .apb_pready(apb_pready), .apb_pslverr(apb_pslverr),
    .flush_i(flush_i),
    .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_data_o(m_data_o),
    .m_chan_o(m_chan_o), .m_last_o(m_last_o), .drop_cnt_o(drop_cnt_o)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Stream monitor: collects handshaken beats and checks beats hold while stalled.
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        stall_checks++;
        checkOutput("stall_hold", {18'b0, m_valid_o, m_last_o, m_chan_o, m_data_o},
                    {18'b0, 1'b1, prev_beat});
      end
      if (m_valid_o && m_ready_i) got_q.push_back({m_last_o, m_chan_o, m_data_o});
      prev_stall = m_valid_o && !m_ready_i;
      prev_beat  = {m_last_o, m_chan_o, m_data_o};
    end
  end

  // Runaway guard.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] mkAddr(input int cl, input int core);
    return 32'((cl << 7) | (core << 3));
  endfunction

  task automatic apbWrite(input int cl, input int core, input logic [7:0] c,
                          output int waits, output logic err);
    @(posedge clk_i); #1;
    apb_psel = 1'b1; apb_pwrite = 1'b1; apb_penable = 1'b0;
    apb_paddr = mkAddr(cl, core); apb_pwdata = {24'b0, c};
    @(posedge clk_i); #1;
    apb_penable = 1'b1;
    waits = 0;
    @(negedge clk_i);
    while (!apb_pready && waits < 200) begin
      @(negedge clk_i);
      waits++;
    end
    err = apb_pslverr;
    if (!apb_pready) checkOutput("apb_write_timeout", {31'b0, apb_pready}, 32'd1);
    @(posedge clk_i); #1;
    apb_psel = 1'b0; apb_penable = 1'b0; apb_pwrite = 1'b0;
  endtask

  task automatic apbRead(input int cl, input int core, output logic [31:0] data, output logic err);
    @(posedge clk_i); #1;
    apb_psel = 1'b1; apb_pwrite = 1'b0; apb_penable = 1'b0;
    apb_paddr = mkAddr(cl, core);
    @(posedge clk_i); #1;
    apb_penable = 1'b1;
    @(negedge clk_i);
    data = apb_prdata;
    err  = apb_pslverr;
    @(posedge clk_i); #1;
    apb_psel = 1'b0; apb_penable = 1'b0;
  endtask

  // Writes a string of characters to one core.
  task automatic applyStimulus(input int cl, input int core, input string s);
    int w;
    logic e;
    for (int i = 0; i < s.len(); i++) apbWrite(cl, core, s[i], w, e);
  endtask

  task automatic pushExp(input int chan, input logic [7:0] d, input logic last);
    exp_q.push_back({last, 5'(chan), d});
  endtask

  task automatic pulseFlush();
    @(posedge clk_i); #1; flush_i = 1'b1;
    @(posedge clk_i); #1; flush_i = 1'b0;
  endtask

  // Waits (bounded) for the expected beats, then compares count and contents.
  task automatic checkStream(input string tag);
    int w;
    w = 0;
    while (got_q.size() < exp_q.size() && w < 400) begin
      @(negedge clk_i);
      w++;
    end
    repeat (8) @(negedge clk_i);
    checkOutput({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      checkOutput($sformatf("%s_beat%0d", tag, i), {18'b0, got_q[i]}, {18'b0, exp_q[i]});
    got_q.delete();
    exp_q.delete();
  endtask

  // Directed test sequence.
  initial begin
    logic [31:0] rd;
    logic        err;
    int          w;

    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;

    @(negedge clk_i);
    checkOutput("rst_valid", {31'b0, m_valid_o}, 32'd0);
    checkOutput("rst_last", {31'b0, m_last_o}, 32'd0);
    checkOutput("rst_data", {24'b0, m_data_o}, 32'd0);
    checkOutput("rst_chan", {27'b0, m_chan_o}, 32'd0);
    checkOutput("rst_drop", {16'b0, drop_cnt_o}, 32'd0);
    apbRead(0, 0, rd, err);
    checkOutput("rst_status", rd, 32'd0);

    $display("[TB] test 1: simple line on core (1,2)");
    applyStimulus(1, 2, "Hi");
    apbRead(1, 2, rd, err);
    checkOutput("t1_status_fill", rd, 32'h0000_0200);
    apbWrite(1, 2, 8'h0A, w, err);
    @(negedge clk_i);
    checkOutput("t1_valid_T1", {31'b0, m_valid_o}, 32'd0);
    @(negedge clk_i);
    checkOutput("t1_valid_T2", {31'b0, m_valid_o}, 32'd1);
    checkOutput("t1_first_data", {24'b0, m_data_o}, 32'h48);
    pushExp(10, 8'h48, 1'b0);
    pushExp(10, 8'h69, 1'b1);
    checkStream("t1");

    $display("[TB] test 2: bare newline on empty channel");
    apbWrite(0, 1, 8'h0A, w, err);
    checkOutput("t2_no_wait", w, 32'd0);
    checkOutput("t2_no_err", {31'b0, err}, 32'd0);
    repeat (4) @(negedge clk_i);
    checkOutput("t2_valid", {31'b0, m_valid_o}, 32'd0);
    checkOutput("t2_drop", {16'b0, drop_cnt_o}, 32'd0);
    apbRead(0, 1, rd, err);
    checkOutput("t2_status", rd, 32'd0);
    checkStream("t2");

    $display("[TB] test 3: auto-wrap on full line, write stalls during drain");
    m_ready_i = 1'b0;
    applyStimulus(2, 5, "abcd");
    repeat (3) @(negedge clk_i);
    checkOutput("t3_drop", {16'b0, drop_cnt_o}, 32'd1);
    checkOutput("t3_valid_held", {31'b0, m_valid_o}, 32'd1);
    checkOutput("t3_chan", {27'b0, m_chan_o}, 32'd21);
    checkOutput("t3_data_a", {24'b0, m_data_o}, 32'h61);
    apbRead(2, 5, rd, err);
    checkOutput("t3_status_commit", rd, 32'h0001_0401);
    fork
      apbWrite(2, 5, 8'h65, w3, e3);
      begin
        repeat (6) @(negedge clk_i);
        checkOutput("t3_pready_stall", {31'b0, apb_pready}, 32'd0);
        @(posedge clk_i); #1 m_ready_i = 1'b1;
      end
    join
    checkOutput("t3_waited", {31'b0, (w3 > 4)}, 32'd1);
    pushExp(21, 8'h61, 1'b0);
    pushExp(21, 8'h62, 1'b0);
    pushExp(21, 8'h63, 1'b0);
    pushExp(21, 8'h64, 1'b1);
    checkStream("t3");
    apbRead(2, 5, rd, err);
    checkOutput("t3_status_after", rd, 32'h0001_0100);
    pulseFlush();
    pushExp(21, 8'h65, 1'b1);
    checkStream("t3_flush");

    $display("[TB] test 4: round-robin order on simultaneous commit");
    applyStimulus(0, 0, "pq");
    applyStimulus(0, 3, "r");
    applyStimulus(0, 5, "st");
    pulseFlush();
    applyStimulus(0, 0, "u");
    apbWrite(0, 0, 8'h0A, w, err);
    pushExp(0, 8'h70, 1'b0);
    pushExp(0, 8'h71, 1'b1);
    pushExp(3, 8'h72, 1'b1);
    pushExp(5, 8'h73, 1'b0);
    pushExp(5, 8'h74, 1'b1);
    pushExp(0, 8'h75, 1'b1);
    checkStream("t4");

    $display("[TB] test 5: toggling ready");
    stall_checks = 0;
    fork
      begin
        repeat (60) begin
          @(posedge clk_i); #1 m_ready_i = ~m_ready_i;
        end
      end
      begin
        applyStimulus(3, 7, "abc");
        apbWrite(3, 7, 8'h0A, w, err);
      end
    join
    @(posedge clk_i); #1 m_ready_i = 1'b1;
    pushExp(31, 8'h61, 1'b0);
    pushExp(31, 8'h62, 1'b0);
    pushExp(31, 8'h63, 1'b1);
    checkStream("t5");
    checkOutput("t5_stalls_seen", {31'b0, (stall_checks > 0)}, 32'd1);

    $display("[TB] test 6: out-of-range access and reset mid-line");
    apbWrite(15, 0, 8'h71, w, err);
    checkOutput("t6_wr_slverr", {31'b0, err}, 32'd1);
    checkOutput("t6_wr_nowait", w, 32'd0);
    apbRead(4, 0, rd, err);
    checkOutput("t6_rd_slverr", {31'b0, err}, 32'd1);
    checkOutput("t6_rd_data", rd, 32'd0);
    checkStream("t6_oor");
    m_ready_i = 1'b0;
    applyStimulus(0, 1, "mno");
    apbWrite(0, 1, 8'h0A, w, err);
    repeat (3) @(negedge clk_i);
    checkOutput("t6_valid_pre", {31'b0, m_valid_o}, 32'd1);
    checkOutput("t6_data_pre", {24'b0, m_data_o}, 32'h6D);
    checkOutput("t6_drop_pre", {16'b0, drop_cnt_o}, 32'd1);
    @(posedge clk_i); #1 rst_ni = 1'b0;
    #1;
    checkOutput("t6_rst_valid", {31'b0, m_valid_o}, 32'd0);
    checkOutput("t6_rst_chan", {27'b0, m_chan_o}, 32'd0);
    checkOutput("t6_rst_drop", {16'b0, drop_cnt_o}, 32'd0);
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    m_ready_i = 1'b1;
    apbRead(0, 1, rd, err);
    checkOutput("t6_status_ch1", rd, 32'd0);
    apbRead(2, 5, rd, err);
    checkOutput("t6_status_ch21", rd, 32'd0);
    checkStream("t6_after_rst");

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
